// File: rtl/usr_seq.sv
// Transfer sequencer for the universal shift register: turns one TX/RX command
// into a cycle-by-cycle usr mode select with bit strobes and a completion pulse.
module usr_seq #(
  parameter int WIDTH = 5,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    cmd,
  input  logic [CW-1:0] len,
  input  logic          hold,
  input  logic          abort,
  output logic          ready,
  output logic          busy,
  output logic [1:0]    usr_sel,
  output logic          bit_en,
  output logic [CW-1:0] bit_cnt,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          hold_q, hold_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [1:0]    sel_q, sel_d;
  logic          bit_en_q, bit_en_d;
  logic          done_q, done_d;
  logic [CW-1:0] len_eff;

  assign len_eff = (len == '0 || len > WIDTH_C) ? WIDTH_C : len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    hold_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d   = cmd;
          len_d   = len_eff;
          cnt_d   = '0;
          state_d = cmd[1] ? SHIFT : LOAD;
        end
      end
      LOAD:  state_d = SHIFT;
      SHIFT: begin
        // hold_q marks the current cycle as a paused one; only active cycles count.
        if (!hold_q) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == len_q) state_d = DONE;
        end
        if (state_d == SHIFT) hold_d = hold;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      hold_d  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    ready_d  = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    bit_en_d = (state_d == SHIFT) && !hold_d;
    sel_d    = 2'b00;
    if (state_d == LOAD)  sel_d = 2'b11;
    if (bit_en_d)         sel_d = cmd_d[0] ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= WIDTH_C;
      cmd_q    <= 2'b00;
      hold_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      sel_q    <= 2'b00;
      bit_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      cmd_q    <= cmd_d;
      hold_q   <= hold_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      sel_q    <= sel_d;
      bit_en_q <= bit_en_d;
      done_q   <= done_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign usr_sel = sel_q;
  assign bit_en  = bit_en_q;
  assign bit_cnt = cnt_q;
  assign done    = done_q;

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq: builds the expected per-cycle output trace of each transfer
// from the command rules and compares it cycle by cycle.
module tb_usr_seq;

  logic       clk = 1'b0;
  logic       rst, start, hold, abort;
  logic [1:0] cmd;
  logic [2:0] len;
  logic       ready, busy, bit_en, done;
  logic [1:0] usr_sel;
  logic [2:0] bit_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [1:0] sel;
    logic       en;
    logic [2:0] cnt;
    logic       done;
  } obs_t;

  usr_seq #(.WIDTH(5), .CW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .len(len),
    .hold(hold), .abort(abort), .ready(ready), .busy(busy),
    .usr_sel(usr_sel), .bit_en(bit_en), .bit_cnt(bit_cnt), .done(done)
  );

  always #5 clk = ~clk;

  // Runs one transfer from a negedge in IDLE and returns at a negedge in IDLE.
  // fixed_k/fixed_p force a pause of fixed_p cycles after shift number fixed_k+1.
  task automatic run_xfer(input logic [1:0] c, input logic [2:0] l, input int pause_pct,
                          input int fixed_k, input int fixed_p, input int abort_at,
                          input bit extra_start, input bit start_abort);
    obs_t exp_q[$];
    bit   pz[$];
    obs_t e, o;
    int   n_len, p, n;
    n_len = (l == 0 || l > 5) ? 5 : int'(l);
    if (!c[1]) begin
      exp_q.push_back({1'b0, 1'b1, 2'b11, 1'b0, 3'd0, 1'b0});
      pz.push_back(1'b0);
    end
    for (int k = 0; k < n_len; k++) begin
      exp_q.push_back({1'b0, 1'b1, (c[0] ? 2'b10 : 2'b01), 1'b1, 3'(k), 1'b0});
      pz.push_back(1'b0);
      if (k + 1 < n_len) begin
        p = (k == fixed_k) ? fixed_p :
            (($urandom_range(99) < pause_pct) ? int'($urandom_range(2, 1)) : 0);
        repeat (p) begin
          exp_q.push_back({1'b0, 1'b1, 2'b00, 1'b0, 3'(k + 1), 1'b0});
          pz.push_back(1'b1);
        end
      end
    end
    exp_q.push_back({1'b0, 1'b1, 2'b00, 1'b0, 3'(n_len), 1'b1});
    pz.push_back(1'b0);
    pz.push_back(1'b0);
    if (abort_at >= 0) while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
    n = exp_q.size();
    $display("xfer cmd=%b len=%0d eff=%0d cycles=%0d abort_at=%0d", c, l, n_len, n, abort_at);

    n_checks++;
    if (!(ready === 1'b1 && busy === 1'b0 && usr_sel === 2'b00 && done === 1'b0)) begin
      $display("FAIL pre_idle: ready=%b busy=%b sel=%b done=%b, want 1 0 00 0",
               ready, busy, usr_sel, done);
    end else n_pass++;

    start = 1'b1; cmd = c; len = l; abort = start_abort;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o = {ready, busy, usr_sel, bit_en, bit_cnt, done};
      e = exp_q[i];
      n_checks++;
      if (o !== e) $display("FAIL cycle%0d: got %b want %b (ready busy sel en cnt done)", i, o, e);
      else n_pass++;
      hold  = pz[i + 1];
      abort = (i == abort_at);
      start = extra_start && (i == 1);
      if (start) cmd = ~c;
      @(posedge clk);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      hold = 1'b0; abort = 1'b0; start = 1'b0;
      o = {ready, busy, usr_sel, bit_en, 3'd0, done};
      e = {1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
      n_checks++;
      if (o !== e) $display("FAIL post_idle%0d: got %b want %b", j, o, e);
      else n_pass++;
      if (j == 0) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; cmd = 2'b00; len = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({ready, busy, usr_sel, bit_en, bit_cnt, done} !== 9'b1_0_00_0_000_0)
      $display("FAIL reset_init: got %b want 100000000", {ready, busy, usr_sel, bit_en, bit_cnt, done});
    else n_pass++;
    start = 1'b1; cmd = 2'b10; len = 3'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!(busy === 1'b1 && bit_cnt === 3'd3))
      $display("FAIL mid_shift: busy=%b cnt=%0d want 1 3", busy, bit_cnt);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("xfer reset mid-shift");
    n_checks++;
    if ({ready, busy, usr_sel, bit_en, bit_cnt, done} !== 9'b1_0_00_0_000_0)
      $display("FAIL reset_mid: got %b want 100000000", {ready, busy, usr_sel, bit_en, bit_cnt, done});
    else n_pass++;
  endtask

  task automatic test_tx_default();   run_xfer(2'b00, 3'd0, 0, -1, 0, -1, 1'b0, 1'b0); endtask
  task automatic test_rx_lsb();       run_xfer(2'b11, 3'd3, 0, -1, 0, -1, 1'b0, 1'b0); endtask
  task automatic test_hold();         run_xfer(2'b01, 3'd5, 0,  1, 2, -1, 1'b0, 1'b0); endtask
  task automatic test_start_abort();  run_xfer(2'b10, 3'd2, 0, -1, 0, -1, 1'b0, 1'b1); endtask

  task automatic test_abort();
    run_xfer(2'b00, 3'd5, 0, -1, 0, 2, 1'b0, 1'b0);
    run_xfer(2'b10, 3'd4, 0, -1, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_len_sat();
    run_xfer(2'b00, 3'd7, 0, -1, 0, -1, 1'b1, 1'b0);
    run_xfer(2'b11, 3'd6, 0, -1, 0, -1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      run_xfer(2'($urandom_range(3)), 3'($urandom_range(7)), 30, -1, 0,
               ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1,
               1'($urandom_range(1)), 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_tx_default();
    test_rx_lsb();
    test_hold();
    test_abort();
    test_len_sat();
    test_start_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
